// File: rtl/csr_access_unit_if.sv
// rtl/csr_access_unit_if.sv - request/response and CSR register-file bus for csr_access_unit
//
// Purpose: bundles every non-clock signal of csr_access_unit.
//   master : execute stage + register file side (drives requests, read data, resp_ready)
//   slave  : csr_access_unit side
// Signals:
//   req_v_i/req_ready_o          request handshake
//   req_op_i/adr/rs1/rs1_data    funct3, CSR address, rs1 field, rs1 value
//   csr_adr_read_o/csr_data_i    register-file read port (combinational read)
//   csr_write_v_o/adr/data       register-file write port
//   resp_v_o/resp_ready_i        response handshake
//   resp_data_o/resp_illegal_o   old CSR value, illegal-instruction flag
interface csr_access_unit_if #(
  parameter int XLEN = 32
);
  logic            req_v_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [11:0]     req_adr_i;
  logic [4:0]      req_rs1_i;
  logic [XLEN-1:0] req_rs1_data_i;
  logic [11:0]     csr_adr_read_o;
  logic [XLEN-1:0] csr_data_i;
  logic            csr_write_v_o;
  logic [11:0]     csr_adr_write_o;
  logic [XLEN-1:0] csr_data_o;
  logic            resp_v_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_data_o;
  logic            resp_illegal_o;

  modport master (
    output req_v_i, req_op_i, req_adr_i, req_rs1_i, req_rs1_data_i, csr_data_i, resp_ready_i,
    input  req_ready_o, csr_adr_read_o, csr_write_v_o, csr_adr_write_o, csr_data_o,
           resp_v_o, resp_data_o, resp_illegal_o
  );

  modport slave (
    input  req_v_i, req_op_i, req_adr_i, req_rs1_i, req_rs1_data_i, csr_data_i, resp_ready_i,
    output req_ready_o, csr_adr_read_o, csr_write_v_o, csr_adr_write_o, csr_data_o,
           resp_v_o, resp_data_o, resp_illegal_o
  );
endinterface

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr read-modify-write sequencer for the machine-mode CSR file
//
// Purpose: accepts one CSR instruction, reads the addressed CSR, writes the
// modified value back (when required and legal) and returns the old value.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    csr_access_unit_if.slave (request, register-file ports, response)
module csr_access_unit #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               reset,
  csr_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [2:0]      r_op;
  logic [11:0]     r_adr;
  logic [4:0]      r_rs1;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_new;
  logic [XLEN-1:0] r_resp_data;
  logic            r_illegal;

  logic            w_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_new;
  logic            w_impl;
  logic            w_write_req;
  logic            w_illegal;

  // Immediate forms take the 5-bit rs1 field as a zero-extended operand.
  assign w_src = r_op[2] ? {{(XLEN-5){1'b0}}, r_rs1} : r_rs1_data;

  always_comb begin
    w_new = bus.csr_data_i;
    case (r_op[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = bus.csr_data_i | w_src;
      2'b11:   w_new = bus.csr_data_i & ~w_src;
      default: w_new = bus.csr_data_i;
    endcase
  end

  always_comb begin
    w_impl = 1'b0;
    case (r_adr)
      12'hF11, 12'hF12, 12'hF13,
      12'h300, 12'h301, 12'h304, 12'h305, 12'h310,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344: w_impl = 1'b1;
      default:                                      w_impl = 1'b0;
    endcase
  end

  // Set/clear with rs1 == x0 (or uimm == 0) is a pure read, so it may target read-only CSRs.
  assign w_write_req = (r_op[1:0] == 2'b01) || (r_rs1 != 5'd0);
  assign w_illegal   = (r_op[1:0] == 2'b00) || !w_impl ||
                       (w_write_req && (r_adr[11:10] == 2'b11));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_adr       <= 12'd0;
      r_rs1       <= 5'd0;
      r_rs1_data  <= '0;
      r_new       <= '0;
      r_resp_data <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op       <= bus.req_op_i;
        r_adr      <= bus.req_adr_i;
        r_rs1      <= bus.req_rs1_i;
        r_rs1_data <= bus.req_rs1_data_i;
      end
      // Read data is only meaningful here; later changes on csr_data_i are ignored.
      if (r_state == S_READ) begin
        r_new       <= w_new;
        r_illegal   <= w_illegal;
        r_resp_data <= w_illegal ? '0 : bus.csr_data_i;
      end
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_ready           = 1'b0;
    bus.csr_write_v_o = 1'b0;
    bus.resp_v_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = !reset;
        if (bus.req_v_i && !reset) w_next_state = S_READ;
      end
      S_READ: begin
        w_next_state = (w_write_req && !w_illegal) ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        // Gated so a reset landing on this cycle never commits a partial write.
        bus.csr_write_v_o = !reset;
        w_next_state      = S_RESP;
      end
      S_RESP: begin
        bus.resp_v_o = !reset;
        if (bus.resp_ready_i) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_accept            = bus.req_v_i && w_ready;
  assign bus.req_ready_o     = w_ready;
  assign bus.csr_adr_read_o  = r_adr;
  assign bus.csr_adr_write_o = r_adr;
  assign bus.csr_data_o      = r_new;
  assign bus.resp_data_o     = r_resp_data;
  assign bus.resp_illegal_o  = r_illegal;

endmodule
